// File: rtl/neopx_pkg.sv
// Shared constants, address map and FSM states for the NeoPixel receiver.
// Optional glitch filter: define NEOPX_RX_GLITCH_FILTER_EN.
package neopx_pkg;

   localparam int LED_RGB  = 24;
   localparam int LED_RGBW = 32;

   localparam logic [7:0] PX_BASE    = 8'h00;
   localparam logic [7:0] STATUS_ADR = 8'h20;
   localparam logic [7:0] CTRL_ADR   = 8'h24;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW,
      FRAME_END
   } rx_state_t;

   function automatic int ns2cyc(input int clk_hz, input int ns);
      return (clk_hz / 1_000_000) * ns / 1000;
   endfunction

endpackage

// File: rtl/wb_neopx_rx_if.sv
// Wishbone slave bundle for the NeoPixel receiver.
// Optional glitch filter: define NEOPX_RX_GLITCH_FILTER_EN.
interface wb_neopx_rx_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0]   wb_adr_i;
   logic [DATA_WIDTH-1:0]   wb_dat_i;
   logic [DATA_WIDTH-1:0]   wb_dat_o;
   logic                    wb_we_i;
   logic [SELECT_WIDTH-1:0] wb_sel_i;
   logic                    wb_stb_i;
   logic                    wb_cyc_i;
   logic                    wb_ack_o;
   logic                    wb_err_o;
   logic                    wb_rty_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i,
      output wb_stb_i, wb_cyc_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i,
      input  wb_stb_i, wb_cyc_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );

endinterface

// File: rtl/neopx_bit_decoder.sv
// Synchronizer, edge detect and pulse-width FSM turning the serial line into bits.
// Optional glitch filter: define NEOPX_RX_GLITCH_FILTER_EN.
module neopx_bit_decoder
   import neopx_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 72_000_000,
   parameter int THRESH_NS   = 600,
   parameter int RESET_NS    = 50_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic en,
   input  logic i_serial,
   output logic bit_valid,
   output logic bit_val,
   output logic frame_end
);

   localparam logic [15:0] C_THR = 16'(ns2cyc(CLK_FREQ_HZ, THRESH_NS));
   localparam logic [15:0] C_RST = 16'(ns2cyc(CLK_FREQ_HZ, RESET_NS));
   localparam logic [15:0] C_SAT = 16'hFFFF;

   logic [1:0] sync;
   logic       prev;
   logic       rise;
   logic       fall;
   logic       glitch;

   rx_state_t   state, state_n;
   rx_state_t   ret, ret_n;
   logic [15:0] hi_cnt, hi_cnt_n;
   logic [15:0] lo_cnt, lo_cnt_n;

   // Idle-high reset values keep a line that is already high from edging.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync <= 2'b11;
         prev <= 1'b1;
      end else begin
         sync <= {sync[0], i_serial};
         prev <= sync[1];
      end
   end

   assign rise = sync[1] & ~prev;
   assign fall = ~sync[1] & prev;

`ifdef NEOPX_RX_GLITCH_FILTER_EN
   localparam logic [15:0] C_MIN = 16'(ns2cyc(CLK_FREQ_HZ, 150));
   assign glitch = hi_cnt < C_MIN;
`else
   assign glitch = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= IDLE;
         ret    <= IDLE;
         hi_cnt <= '0;
         lo_cnt <= '0;
      end else begin
         state  <= state_n;
         ret    <= ret_n;
         hi_cnt <= hi_cnt_n;
         lo_cnt <= lo_cnt_n;
      end
   end

   // A rejected pulse restores the pre-pulse state; lo_cnt is untouched by it.
   always_comb begin
      state_n   = state;
      ret_n     = ret;
      hi_cnt_n  = hi_cnt;
      lo_cnt_n  = lo_cnt;
      bit_valid = 1'b0;
      bit_val   = 1'b0;
      frame_end = 1'b0;
      unique case (state)
         IDLE: begin
            if (rise) begin
               state_n  = HIGH;
               ret_n    = IDLE;
               hi_cnt_n = 16'd1;
            end
         end
         HIGH: begin
            if (fall) begin
               if (glitch) begin
                  state_n = ret;
               end else begin
                  bit_valid = 1'b1;
                  bit_val   = hi_cnt >= C_THR;
                  state_n   = LOW;
                  lo_cnt_n  = 16'd1;
               end
            end else if (hi_cnt != C_SAT) begin
               hi_cnt_n = hi_cnt + 16'd1;
            end
         end
         LOW: begin
            if (rise) begin
               state_n  = HIGH;
               ret_n    = LOW;
               hi_cnt_n = 16'd1;
            end else if (lo_cnt >= C_RST) begin
               state_n = FRAME_END;
            end else if (lo_cnt != C_SAT) begin
               lo_cnt_n = lo_cnt + 16'd1;
            end
         end
         FRAME_END: begin
            frame_end = 1'b1;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (!en) begin
         state_n = IDLE;
      end
   end

endmodule

// File: rtl/wb_neopx_rx.sv
// Wishbone-readable NeoPixel receiver: pixel buffer, frame status, control.
// Optional glitch filter: define NEOPX_RX_GLITCH_FILTER_EN.
module wb_neopx_rx
   import neopx_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int CLK_FREQ_HZ  = 72_000_000,
   parameter int BITS_PER_PX  = 32,
   parameter int THRESH_NS    = 600,
   parameter int RESET_NS     = 50_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_serial,
   wb_neopx_rx_if.slave wb
);

   localparam logic [31:0] PX_MASK =
      (BITS_PER_PX == LED_RGB) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
   localparam logic [4:0] LAST_BIT = 5'(BITS_PER_PX - 1);

   logic        bit_valid;
   logic        bit_val;
   logic        frame_end;

   logic [31:0] shreg;
   logic [31:0] word_n;
   logic [4:0]  bit_cnt;
   logic [3:0]  px_idx;
   logic [31:0] led [8];
   logic [3:0]  px_count;
   logic        frame_valid;
   logic        overflow;
   logic        partial;
   logic [7:0]  frame_cnt;
   logic        enable;
   logic        ack;

   logic        req;
   logic        wr;
   logic [3:0]  idx;
   logic        px_sel;
   logic        st_sel;
   logic        ct_sel;
   logic        st_clr;
   logic [31:0] status;
   logic [DATA_WIDTH-1:0] rdata;

   logic [SELECT_WIDTH-1:0] unused_sel;
   logic                    unused_bits;

   neopx_bit_decoder #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .THRESH_NS   (THRESH_NS),
      .RESET_NS    (RESET_NS)
   ) u_dec (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .en        (enable),
      .i_serial  (i_serial),
      .bit_valid (bit_valid),
      .bit_val   (bit_val),
      .frame_end (frame_end)
   );

   assign word_n = {shreg[30:0], bit_val};

   assign req    = wb.wb_cyc_i & wb.wb_stb_i & ~ack;
   assign wr     = req & wb.wb_we_i;
   assign idx    = wb.wb_adr_i[5:2];
   assign px_sel = idx[3] == PX_BASE[5];
   assign st_sel = idx == STATUS_ADR[5:2];
   assign ct_sel = idx == CTRL_ADR[5:2];
   assign st_clr = wr & st_sel;

   assign status = {16'h0, frame_cnt, 1'b0,
                    partial, overflow, frame_valid, px_count};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         shreg       <= '0;
         bit_cnt     <= '0;
         px_idx      <= '0;
         px_count    <= '0;
         frame_valid <= 1'b0;
         overflow    <= 1'b0;
         partial     <= 1'b0;
         frame_cnt   <= '0;
         enable      <= 1'b1;
         ack         <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            led[i] <= '0;
         end
      end else begin
         ack <= req;
         if (wr && ct_sel) begin
            enable <= wb.wb_dat_i[0];
         end
         if (bit_valid) begin
            shreg <= word_n;
            if (bit_cnt == LAST_BIT) begin
               bit_cnt <= '0;
               if (px_idx == 4'd8) begin
                  overflow <= 1'b1;
               end else begin
                  led[px_idx[2:0]] <= word_n & PX_MASK;
                  px_idx           <= px_idx + 4'd1;
               end
            end else begin
               bit_cnt <= bit_cnt + 5'd1;
            end
         end
         // A frame commit in the same cycle keeps the flags set.
         if (st_clr && !frame_end) begin
            frame_valid <= 1'b0;
            overflow    <= 1'b0;
            partial     <= 1'b0;
         end
         if (frame_end) begin
            px_count    <= px_idx;
            partial     <= bit_cnt != '0;
            frame_valid <= 1'b1;
            frame_cnt   <= frame_cnt + 8'd1;
            px_idx      <= '0;
            bit_cnt     <= '0;
         end
      end
   end

   always_comb begin
      rdata = '0;
      unique case (1'b1)
         px_sel:  rdata = DATA_WIDTH'(led[idx[2:0]]);
         st_sel:  rdata = DATA_WIDTH'(status);
         ct_sel:  rdata = DATA_WIDTH'(enable);
         default: rdata = '0;
      endcase
   end

   assign wb.wb_dat_o = ack ? rdata : '0;
   assign wb.wb_ack_o = ack;
   assign wb.wb_err_o = 1'b0;
   assign wb.wb_rty_o = 1'b0;

   assign unused_sel  = wb.wb_sel_i;
   assign unused_bits = ^{wb.wb_adr_i[ADDR_WIDTH-1:6], wb.wb_adr_i[1:0],
                          wb.wb_dat_i[DATA_WIDTH-1:1]};

endmodule

// File: tb/tb_wb_neopx_rx.sv
// Randomized self-checking bench for wb_neopx_rx against a bit-list frame model.
// Glitch expectations follow NEOPX_RX_GLITCH_FILTER_EN.
module tb_wb_neopx_rx;

   localparam int MHZ   = 72;
   localparam int C_THR = MHZ * 600 / 1000;
   localparam int C_RST = MHZ * 50_000 / 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic serial = 1'b0;

   int checks = 0;
   int passed = 0;

   bit          bits[$];
   logic [31:0] exp_led [8];
   logic [3:0]  exp_cnt;
   logic        exp_fv, exp_ovf, exp_part;
   logic [7:0]  exp_fcnt;

   wb_neopx_rx_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) wb ();

   wb_neopx_rx #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .CLK_FREQ_HZ (72_000_000),
      .BITS_PER_PX (32)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_serial (serial),
      .wb       (wb.slave)
   );

   always #7 clk = ~clk;

   function automatic logic [31:0] exp_status();
      return {16'h0, exp_fcnt, 1'b0, exp_part, exp_ovf, exp_fv, exp_cnt};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) exp_led[i] = '0;
      exp_cnt = '0; exp_fv = 0; exp_ovf = 0; exp_part = 0; exp_fcnt = '0;
      bits.delete();
   endtask

   // Frame outcome from the list of decoded bits alone.
   task automatic model_frame();
      int n, words;
      logic [31:0] v;
      n = bits.size();
      words = n / 32;
      for (int k = 0; k < words && k < 8; k++) begin
         v = '0;
         for (int b = 0; b < 32; b++) v = {v[30:0], bits[k*32+b]};
         exp_led[k] = v;
      end
      exp_cnt  = 4'((words > 8) ? 8 : words);
      if (words > 8) exp_ovf = 1;
      exp_part = (n % 32) != 0;
      exp_fv   = 1;
      exp_fcnt = exp_fcnt + 8'd1;
      bits.delete();
   endtask

   task automatic drive_pulse(input int hi, input int lo);
      serial = 1'b1;
      repeat (hi) @(negedge clk);
      serial = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic send_bit(input bit b);
      int hi;
      hi = b ? $urandom_range(60, 45) : $urandom_range(30, 12);
      drive_pulse(hi, $urandom_range(16, 8));
      bits.push_back(b);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic end_frame();
      repeat (C_RST + 100) @(negedge clk);
      model_frame();
   endtask

   task automatic wb_xfer(input logic [31:0] adr, input logic we,
                          input logic [31:0] wd, output logic [31:0] rd);
      int n;
      n = 0;
      rd = '0;
      @(negedge clk);
      wb.wb_adr_i = adr;
      wb.wb_we_i  = we;
      wb.wb_dat_i = wd;
      wb.wb_cyc_i = 1'b1;
      wb.wb_stb_i = 1'b1;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!wb.wb_ack_o && n < 16);
      if (!wb.wb_ack_o) begin
         checks++;
         $display("FAIL ack_timeout adr=%h got no ack in 16 cycles", adr);
      end else begin
         rd = wb.wb_dat_o;
      end
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      wb.wb_we_i  = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (wb.wb_ack_o !== 1'b0)
         $display("FAIL reset_ack got %b want 0", wb.wb_ack_o);
      else passed++;
      rst = 1'b0;
      model_reset();
      wb_xfer(32'h00, 0, 0, d);
      checks++;
      if (d !== 32'h0) $display("FAIL reset_px0 got %h want 0", d);
      else passed++;
      wb_xfer(32'h20, 0, 0, d);
      checks++;
      if (d !== 32'h0) $display("FAIL reset_status got %h want 0", d);
      else passed++;
      wb_xfer(32'h24, 0, 0, d);
      checks++;
      if (d !== 32'h1) $display("FAIL reset_ctrl got %h want 1", d);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [3:0] got;
      @(negedge clk);
      wb.wb_adr_i = 32'h24;
      wb.wb_we_i  = 1'b0;
      wb.wb_cyc_i = 1'b1;
      wb.wb_stb_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         got[3-i] = wb.wb_ack_o;
      end
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      @(negedge clk);
      checks++;
      if (got !== 4'b1010) $display("FAIL b2b_ack got %b want 1010", got);
      else passed++;
   endtask

   task automatic test_known_word();
      logic [31:0] w, d;
      w = 32'hA5C3_0F81;
      for (int i = 31; i >= 0; i--) begin
         drive_pulse(w[i] ? 58 : 29, w[i] ? 29 : 58);
         bits.push_back(w[i]);
      end
      end_frame();
      wb_xfer(32'h00, 0, 0, d);
      checks++;
      if (d !== 32'hA5C3_0F81) $display("FAIL known_px0 got %h want a5c30f81", d);
      else passed++;
      wb_xfer(32'h20, 0, 0, d);
      checks++;
      if (d !== 32'h0000_0111) $display("FAIL known_status got %h want 00000111", d);
      else passed++;
   endtask

   task automatic test_threshold();
      logic [31:0] w, d;
      w = $urandom;
      for (int i = 31; i >= 0; i--) begin
         drive_pulse(w[i] ? C_THR : C_THR - 1, 10);
         bits.push_back(w[i]);
      end
      end_frame();
      wb_xfer(32'h00, 0, 0, d);
      checks++;
      if (d !== exp_led[0]) $display("FAIL thresh_px0 got %h want %h", d, exp_led[0]);
      else passed++;
      wb_xfer(32'h20, 0, 0, d);
      checks++;
      if (d !== exp_status()) $display("FAIL thresh_status got %h want %h", d, exp_status());
      else passed++;
   endtask

   task automatic test_loopback();
      logic [31:0] d;
      for (int k = 1; k <= 8; k++) send_word(32'h1111_1111 * k);
      end_frame();
      for (int k = 0; k < 8; k++) begin
         wb_xfer(32'(k * 4), 0, 0, d);
         checks++;
         if (d !== exp_led[k]) $display("FAIL loop_px%0d got %h want %h", k, d, exp_led[k]);
         else passed++;
      end
      wb_xfer(32'h20, 0, 0, d);
      checks++;
      if (d !== exp_status()) $display("FAIL loop_status got %h want %h", d, exp_status());
      else passed++;
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      for (int k = 0; k < 10; k++) send_word($urandom);
      end_frame();
      for (int k = 0; k < 8; k++) begin
         wb_xfer(32'(k * 4), 0, 0, d);
         checks++;
         if (d !== exp_led[k]) $display("FAIL ovf_px%0d got %h want %h", k, d, exp_led[k]);
         else passed++;
      end
      wb_xfer(32'h20, 0, 0, d);
      checks++;
      if (d !== exp_status()) $display("FAIL ovf_status got %h want %h", d, exp_status());
      else passed++;
      wb_xfer(32'h20, 1, 32'hFFFF_FFFF, d);
      exp_fv = 0; exp_ovf = 0; exp_part = 0;
      wb_xfer(32'h20, 0, 0, d);
      checks++;
      if (d !== exp_status()) $display("FAIL ovf_clear got %h want %h", d, exp_status());
      else passed++;
   endtask

   task automatic test_partial();
      logic [31:0] d;
      for (int i = 0; i < 20; i++) send_bit(1'($urandom));
      end_frame();
      wb_xfer(32'h20, 0, 0, d);
      checks++;
      if (d !== exp_status()) $display("FAIL part_status got %h want %h", d, exp_status());
      else passed++;
      wb_xfer(32'h20, 1, 0, d);
      exp_fv = 0; exp_ovf = 0; exp_part = 0;
      wb_xfer(32'h20, 0, 0, d);
      checks++;
      if (d[6:4] !== 3'b000) $display("FAIL part_clear got %b want 000", d[6:4]);
      else passed++;
   endtask

   task automatic test_glitch();
      logic [31:0] w, d;
      w = $urandom;
      for (int i = 31; i >= 0; i--) begin
         send_bit(w[i]);
         if (i == 16) begin
            drive_pulse(5, 12);
`ifndef NEOPX_RX_GLITCH_FILTER_EN
            bits.push_back(1'b0);
`endif
         end
      end
      end_frame();
      wb_xfer(32'h00, 0, 0, d);
      checks++;
      if (d !== exp_led[0]) $display("FAIL glitch_px0 got %h want %h", d, exp_led[0]);
      else passed++;
      wb_xfer(32'h20, 0, 0, d);
      checks++;
      if (d !== exp_status()) $display("FAIL glitch_status got %h want %h", d, exp_status());
      else passed++;
   endtask

   task automatic test_enable();
      logic [31:0] d;
      wb_xfer(32'h24, 1, 0, d);
      wb_xfer(32'h24, 0, 0, d);
      checks++;
      if (d !== 32'h0) $display("FAIL en_ctrl_off got %h want 0", d);
      else passed++;
      for (int i = 0; i < 8; i++) drive_pulse($urandom_range(60, 12), 10);
      repeat (C_RST + 100) @(negedge clk);
      wb_xfer(32'h20, 0, 0, d);
      checks++;
      if (d !== exp_status()) $display("FAIL en_status got %h want %h", d, exp_status());
      else passed++;
      wb_xfer(32'h24, 1, 1, d);
      wb_xfer(32'h24, 0, 0, d);
      checks++;
      if (d !== 32'h1) $display("FAIL en_ctrl_on got %h want 1", d);
      else passed++;
   endtask

   task automatic test_ignored_writes();
      logic [31:0] d;
      wb_xfer(32'h04, 1, $urandom, d);
      wb_xfer(32'h04, 0, 0, d);
      checks++;
      if (d !== exp_led[1]) $display("FAIL ro_px1 got %h want %h", d, exp_led[1]);
      else passed++;
      wb_xfer(32'h30, 1, 32'hFFFF_FFFF, d);
      wb_xfer(32'h30, 0, 0, d);
      checks++;
      if (d !== 32'h0) $display("FAIL unmapped got %h want 0", d);
      else passed++;
   endtask

   task automatic test_reset_midframe();
      logic [31:0] d;
      for (int i = 0; i < 16; i++) send_bit(1'($urandom));
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int k = 0; k < 8; k++) begin
         wb_xfer(32'(k * 4), 0, 0, d);
         checks++;
         if (d !== 32'h0) $display("FAIL rstmid_px%0d got %h want 0", k, d);
         else passed++;
      end
      wb_xfer(32'h20, 0, 0, d);
      checks++;
      if (d !== 32'h0) $display("FAIL rstmid_status got %h want 0", d);
      else passed++;
      send_word($urandom);
      send_word($urandom);
      end_frame();
      for (int k = 0; k < 2; k++) begin
         wb_xfer(32'(k * 4), 0, 0, d);
         checks++;
         if (d !== exp_led[k]) $display("FAIL after_rst_px%0d got %h want %h", k, d, exp_led[k]);
         else passed++;
      end
      wb_xfer(32'h20, 0, 0, d);
      checks++;
      if (d !== exp_status()) $display("FAIL after_rst_status got %h want %h", d, exp_status());
      else passed++;
   endtask

   initial begin
      wb.wb_adr_i = '0;
      wb.wb_dat_i = '0;
      wb.wb_we_i  = 1'b0;
      wb.wb_sel_i = '1;
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_back_to_back();
      test_known_word();
      test_threshold();
      test_loopback();
      test_overflow();
      test_partial();
      test_glitch();
      test_enable();
      test_ignored_writes();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/wb_neopx_rx.md
# wb_neopx_rx

Wishbone-readable NeoPixel (WS2812/SK6812) bitstream receiver. It decodes a single-wire NeoPixel serial stream into up to 8 pixel words and exposes them, plus frame status, on a Wishbone slave port. It sits beside the NeoPixel transmitter for loopback self-test and for monitoring the DOUT of a strip under test.

## Interface
Parameters:
- DATA_WIDTH, 32, Wishbone data width
- ADDR_WIDTH, 32, Wishbone address width
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width (ignored)
- CLK_FREQ_HZ, 72_000_000, i_clk frequency; legal range 10–200 MHz
- BITS_PER_PX, 32, bits per pixel word: 24 (WS2812 RGB) or 32 (SK6812 RGBW)
- THRESH_NS, 600, high-pulse width separating a 0 bit from a 1 bit
- RESET_NS, 50_000, low time that terminates a frame

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- wb_adr_i  in  ADDR_WIDTH  byte address; bits [5:2] decoded
- wb_dat_i  in  DATA_WIDTH  write data
- wb_dat_o  out  DATA_WIDTH  read data
- wb_we_i  in  1  write enable
- wb_sel_i  in  SELECT_WIDTH  byte select (ignored)
- wb_stb_i, wb_cyc_i  in  1  strobe, cycle
- wb_ack_o  out  1  acknowledge
- wb_err_o, wb_rty_o  out  1  tied 0
- i_serial  in  1  asynchronous NeoPixel data input

## Operation
- Cycle constants are computed at elaboration: C_THR = (CLK_FREQ_HZ/1_000_000)*THRESH_NS/1000 and C_RST = (CLK_FREQ_HZ/1_000_000)*RESET_NS/1000. At 72 MHz these are 43 and 3600.
- i_serial passes through a 2-FF synchronizer. The edge-detect register resets to 1, so a line that is high at reset release produces no false edge.
- The FSM has four states:
  - IDLE: wait for a rising edge, then go to HIGH and clear the counter.
  - HIGH: count cycles. On the falling edge the bit value is 1 if count ≥ C_THR, else 0; shift it into the word MSB-first, then go to LOW.
  - LOW: count cycles. A rising edge goes to HIGH. When count reaches C_RST, go to FRAME_END.
  - FRAME_END: commit status, then go to IDLE.
- The pulse counter is 16 bits and saturates.
- When the bit counter reaches BITS_PER_PX-1, the word is written to ledData[px_idx] (zero-extended when BITS_PER_PX is 24) and px_idx increments.
  - px_idx saturates at 8.
  - Words received while px_idx is 8 are discarded and set overflow.
- FRAME_END does all of the following in one cycle:
  - px_count ← px_idx
  - partial ← (bit counter ≠ 0)
  - frame_valid ← 1
  - frame_cnt ← frame_cnt + 1 (8 bits, wraps 255→0)
  - clear px_idx and the bit counter
- Address map:
  - 0x00–0x1C: pixel words, read-only. Writes are acked and ignored.
  - 0x20 STATUS: [3:0] px_count, [4] frame_valid, [5] overflow, [6] partial, [15:8] frame_cnt. Any write clears bits 4–6.
  - 0x24 CTRL: bit0 enable (reset 1). With enable at 0 the FSM is held in IDLE; the counters and status keep their values.
  - Other addresses read 0; writes are ignored.
- If a STATUS clear and FRAME_END occur in the same cycle, FRAME_END wins (the flags end up set).
- Reset clears: ledData, status, frame_cnt, FSM → IDLE, wb_ack_o = 0, wb_dat_o = 0. A reset mid-frame discards the partial frame.

## Timing
- wb_ack_o asserts the cycle after cyc&stb is seen with ack low, for exactly one cycle. Back-to-back accesses therefore get ack every other cycle.
- wb_dat_o is combinational from wb_adr_i and is valid while ack is high.
- Input to decision latency: 2 synchronizer cycles + 1 edge-detect cycle.
- A pixel word is readable 1 cycle after its last falling edge.
- STATUS updates 1 cycle after the low count reaches C_RST.
- A bit decision exactly at count == C_THR yields 1.

## Configuration
- NEOPX_RX_GLITCH_FILTER_EN defined: high pulses shorter than C_MIN = (CLK_FREQ_HZ/1_000_000)*150/1000 cycles (10 at 72 MHz) are ignored. The FSM returns to its prior state and the low count continues from the stored value.
- Not defined: every high pulse of ≥1 cycle is decoded as a bit.

## Structure
- Package neopx_pkg holds:
  - the ns→cycles constant function
  - LED type constants (24/32)
  - the address offsets (PX_BASE 0x00, STATUS 0x20, CTRL 0x24)
  - the FSM state enum
- Sub-module neopx_bit_decoder holds the synchronizer, edge detect, pulse counter, FSM and glitch filter. Its outputs are bit_valid, bit_val and frame_end.
- The top module holds the shift register, pixel buffer, status and the Wishbone logic.

## Test plan
- 32 bits of 0xA5C3_0F81 at 72 MHz, using 29-cycle highs for 0 bits and 58-cycle highs for 1 bits, then 3600 low cycles → ledData[0] = 0xA5C30F81; STATUS = 0x0000_0111 (px_count 1, frame_valid set, frame_cnt 1).
- Loopback from the NeoPixel transmitter with 8 words 0x11111111…0x88888888 → all 8 read back identical; px_count = 8; overflow = 0.
- 10 words in one frame → words 0–7 stored; overflow = 1; px_count = 8.
- 20 bits then reset-length low → partial = 1, px_count = 0. A write to 0x20 then gives STATUS [6:4] = 0.
- i_rst asserted after 16 bits → all reads 0; the next full frame decodes correctly.
- With NEOPX_RX_GLITCH_FILTER_EN defined, a 5-cycle high inserted mid-frame → ignored and the word is unchanged. Without the macro → the bit count shifts and partial = 1.
